// File: rtl/key_cursor_ctrl_pkg.sv
// Shared constants and types for the keypad cursor controller.
// Key codes, command encodings and FSM state.
package go_pkg;

  localparam int BOARD_SIZE_DEF = 19;

  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_DOWN  = 4'd9;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_PLACE = 4'd5;
  localparam logic [3:0] KEY_PASS  = 4'd12;
  localparam logic [3:0] KEY_UNDO  = 4'd15;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_PLACE = 2'b01;
  localparam logic [1:0] CMD_PASS  = 2'b10;
  localparam logic [1:0] CMD_UNDO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_EXEC,
    S_ISSUE
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_DEC,
    DIR_INC
  } dir_t;

endpackage

// File: rtl/key_cursor_ctrl_if.sv
// Key-event and command handshakes of the cursor controller.
// master = controller side, slave = scanner / game-logic side.
interface key_cursor_ctrl_if;
  logic [3:0] pressed_index;
  logic       key_valid;
  logic       key_received;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [4:0] cmd_x;
  logic [4:0] cmd_y;
  logic       cmd_ready;

  modport master (
    input  pressed_index, key_valid, cmd_ready,
    output key_received, cmd_valid, cmd_type, cmd_x, cmd_y
  );

  modport slave (
    output pressed_index, key_valid, cmd_ready,
    input  key_received, cmd_valid, cmd_type, cmd_x, cmd_y
  );
endinterface

// File: rtl/key_cursor_ctrl_step.sv
// One-axis cursor step with wrap or clamp at the board edges.
// Result is always inside 0..BOARD_SIZE-1.
module cursor_step
  import go_pkg::*;
#(
  parameter int BOARD_SIZE = BOARD_SIZE_DEF,
  parameter bit WRAP       = 1'b1
) (
  input  logic [4:0] value,
  input  dir_t       dir,
  output logic [4:0] next,
  output logic       changed
);

  localparam logic [4:0] MAX = 5'(BOARD_SIZE - 1);

  always_comb begin
    next = value;
    unique case (dir)
      DIR_DEC: begin
        if (value == 5'd0)
          next = WRAP ? MAX : 5'd0;
        else
          next = value - 5'd1;
      end
      DIR_INC: begin
        if (value >= MAX)
          next = WRAP ? 5'd0 : MAX;
        else
          next = value + 5'd1;
      end
      default: next = value;
    endcase
    changed = (next != value);
  end

endmodule

// File: rtl/key_cursor_ctrl.sv
// Decodes keypad events into cursor moves and game commands.
// Commands leave over a valid/ready handshake carrying the cursor.
module key_cursor_ctrl
  import go_pkg::*;
#(
  parameter int BOARD_SIZE = BOARD_SIZE_DEF,
  parameter bit WRAP       = 1'b1,
  parameter int CUR_INIT   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  key_cursor_ctrl_if.master bus,
  output logic [4:0] cursor_x,
  output logic [4:0] cursor_y,
  output logic       cursor_moved,
  output logic       bad_key
);

  state_t     state, state_n;
  logic [3:0] key_r, key_n;
  logic [4:0] cx_n, cy_n;
  logic       moved_n, bad_n, ack_r, ack_n;
  logic       cv_r, cv_n;
  logic [1:0] ct_r, ct_n;
  logic [4:0] cmx_r, cmx_n, cmy_r, cmy_n;

  dir_t       dir_x, dir_y;
  logic       is_cmd, unmapped;
  logic [1:0] cmd_code;
  logic [4:0] nx, ny;
  logic       chx, chy;

  always_comb begin
    dir_x    = DIR_NONE;
    dir_y    = DIR_NONE;
    is_cmd   = 1'b0;
    unmapped = 1'b0;
    cmd_code = CMD_NONE;
    unique case (1'b1)
      key_r == KEY_UP:    dir_y = DIR_DEC;
      key_r == KEY_DOWN:  dir_y = DIR_INC;
      key_r == KEY_LEFT:  dir_x = DIR_DEC;
      key_r == KEY_RIGHT: dir_x = DIR_INC;
      key_r == KEY_PLACE: begin
        is_cmd   = 1'b1;
        cmd_code = CMD_PLACE;
      end
      key_r == KEY_PASS: begin
        is_cmd   = 1'b1;
        cmd_code = CMD_PASS;
      end
      key_r == KEY_UNDO: begin
        is_cmd   = 1'b1;
        cmd_code = CMD_UNDO;
      end
      default: unmapped = 1'b1;
    endcase
  end

  cursor_step #(.BOARD_SIZE(BOARD_SIZE), .WRAP(WRAP)) u_step_x (
    .value   (cursor_x),
    .dir     (dir_x),
    .next    (nx),
    .changed (chx)
  );

  cursor_step #(.BOARD_SIZE(BOARD_SIZE), .WRAP(WRAP)) u_step_y (
    .value   (cursor_y),
    .dir     (dir_y),
    .next    (ny),
    .changed (chy)
  );

  always_comb begin
    state_n = state;
    key_n   = key_r;
    cx_n    = cursor_x;
    cy_n    = cursor_y;
    moved_n = 1'b0;
    bad_n   = 1'b0;
    ack_n   = 1'b0;
    cv_n    = cv_r;
    ct_n    = ct_r;
    cmx_n   = cmx_r;
    cmy_n   = cmy_r;
    unique case (state)
      S_IDLE: begin
        if (bus.key_valid) begin
          key_n   = bus.pressed_index;
          ack_n   = 1'b1;
          state_n = S_ACK;
        end
      end
      S_ACK: state_n = S_EXEC;
      S_EXEC: begin
        state_n = S_IDLE;
        if (unmapped) begin
          bad_n = 1'b1;
        end else if (en && is_cmd) begin
          cv_n    = 1'b1;
          ct_n    = cmd_code;
          cmx_n   = cursor_x;
          cmy_n   = cursor_y;
          state_n = S_ISSUE;
        end else if (en) begin
          cx_n    = nx;
          cy_n    = ny;
          moved_n = chx | chy;
        end
      end
      S_ISSUE: begin
        if (bus.cmd_ready) begin
          cv_n    = 1'b0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      key_r        <= 4'd0;
      cursor_x     <= 5'(CUR_INIT);
      cursor_y     <= 5'(CUR_INIT);
      cursor_moved <= 1'b0;
      bad_key      <= 1'b0;
      ack_r        <= 1'b0;
      cv_r         <= 1'b0;
      ct_r         <= CMD_NONE;
      cmx_r        <= 5'd0;
      cmy_r        <= 5'd0;
    end else begin
      state        <= state_n;
      key_r        <= key_n;
      cursor_x     <= cx_n;
      cursor_y     <= cy_n;
      cursor_moved <= moved_n;
      bad_key      <= bad_n;
      ack_r        <= ack_n;
      cv_r         <= cv_n;
      ct_r         <= ct_n;
      cmx_r        <= cmx_n;
      cmy_r        <= cmy_n;
    end
  end

  assign bus.key_received = ack_r;
  assign bus.cmd_valid    = cv_r;
  assign bus.cmd_type     = ct_r;
  assign bus.cmd_x        = cmx_r;
  assign bus.cmd_y        = cmy_r;

endmodule
